mips_mc_controller: RTL

Multi-cycle control FSM for the MIPS datapath. It sequences each instruction through the FETCH, DECODE, EXEC, MEM and WB states and drives every datapath control line: RegDst, RegSrc, WriteSrc, RegWrite, AluSrc, MemToReg, PcSrc1, PcSrc2 and AluOp. It adds the instruction-register load, the PC load enable and request/ready handshakes to both memories. It also flags illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/mips_mc_controller.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath controls and memory handshakes, traps on illegal ops and memory stalls.
module mips_mc_controller #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             RegDst,
  output logic             RegSrc,
  output logic             WriteSrc,
  output logic             RegWrite,
  output logic             AluSrc,
  output logic             MemToReg,
  output logic             PcSrc1,
  output logic [1:0]       PcSrc2,
  output logic [2:0]       AluOp,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;

  logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_addi, is_slti, is_j, is_jal;
  logic r_legal, legal, use_imm;
  logic [2:0] r_aluop, alu_op;

  assign is_r    = (opcode == 6'h00);
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_beq  = (opcode == 6'h04);
  assign is_bne  = (opcode == 6'h05);
  assign is_addi = (opcode == 6'h08);
  assign is_slti = (opcode == 6'h0A);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);

  always_comb begin
    r_legal = 1'b1;
    r_aluop = 3'b000;
    case (funct)
      6'h20:   r_aluop = 3'b000;
      6'h22:   r_aluop = 3'b001;
      6'h24:   r_aluop = 3'b010;
      6'h25:   r_aluop = 3'b011;
      6'h2A:   r_aluop = 3'b100;
      6'h08:   r_aluop = 3'b000;
      default: r_legal = 1'b0;
    endcase
  end

  assign legal   = is_r ? r_legal
                 : (is_lw | is_sw | is_beq | is_bne | is_addi | is_slti | is_j | is_jal);
  assign use_imm = is_lw | is_sw | is_addi | is_slti;
  assign alu_op  = is_r               ? r_aluop :
                   (is_beq | is_bne)  ? 3'b001  :
                   is_slti            ? 3'b100  : 3'b000;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    RegDst     = 1'b0;
    RegSrc     = 1'b0;
    WriteSrc   = 1'b0;
    RegWrite   = 1'b0;
    AluSrc     = 1'b0;
    MemToReg   = 1'b0;
    PcSrc1     = 1'b0;
    PcSrc2     = 2'b00;
    AluOp      = 3'b000;
    trap       = 1'b0;
    trap_cause = cause_q;
    instret    = instret_q;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          wait_d   = '0;
          state_d  = S_DECODE;
        end else if (wait_q + 8'd1 == LIMIT) begin
          wait_d   = '0;
          cause_d  = 2'b10;
          state_d  = S_TRAP;
        end else begin
          wait_d   = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_TRAP;
        if (!legal) cause_d = 2'b01;
      end
      S_EXEC: begin
        AluSrc = use_imm;
        AluOp  = alu_op;
        if (is_beq | is_bne) begin
          PcSrc1   = is_beq ? zero : ~zero;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else if (is_j | is_jal | is_jr) begin
          PcSrc2   = is_jr ? 2'b01 : 2'b10;
          RegSrc   = is_jal;
          RegWrite = is_jal;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = (is_lw | is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        // address operands stay driven so the ALU output is stable for memory
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        AluSrc   = 1'b1;
        AluOp    = alu_op;
        if (dmem_ready) begin
          wait_d   = '0;
          pc_write = is_sw;
          state_d  = is_sw ? S_FETCH : S_WB;
        end else if (wait_q + 8'd1 == LIMIT) begin
          wait_d   = '0;
          cause_d  = 2'b11;
          state_d  = S_TRAP;
        end else begin
          wait_d   = wait_q + 8'd1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        WriteSrc = 1'b1;
        pc_write = 1'b1;
        RegDst   = is_r;
        AluSrc   = use_imm;
        MemToReg = is_lw;
        AluOp    = alu_op;
        state_d  = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0; dmem_req = 1'b0; dmem_we  = 1'b0; ir_write = 1'b0;
      pc_write = 1'b0; RegDst   = 1'b0; RegSrc   = 1'b0; WriteSrc = 1'b0;
      RegWrite = 1'b0; AluSrc   = 1'b0; MemToReg = 1'b0; PcSrc1   = 1'b0;
      PcSrc2   = 2'b00; AluOp   = 3'b000; trap   = 1'b0; trap_cause = 2'b00;
      instret  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (pc_write) instret_q <= instret_q + CNT_W'(1);
    end
  end
endmodule
